// File: rtl/seg_pkg.sv
// Shared segment glyphs and helpers for the multiplexed seven-segment driver.
// All patterns are active low, bit order g..a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Letters used to spell mode names in text mode
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_S   = 7'b0010010;
    localparam logic [6:0] SEG_Y   = 7'b0010001;
    localparam logic [6:0] SEG_R_L = 7'b0101111;
    localparam logic [6:0] SEG_G_L = 7'b0010000;
    localparam logic [6:0] SEG_U   = 7'b1000001;
    localparam logic [6:0] SEG_H   = 7'b0001001;
    localparam logic [6:0] SEG_D_L = 7'b0100001;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Controller-to-display bundle: value load handshake, display controls and pin outputs.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
);
    logic [BIN_W-1:0]        value_in;
    logic                    value_load;
    logic                    busy;
    logic                    text_mode;
    logic [7*NUM_DIGITS-1:0] text_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output value_in, value_load, text_mode, text_in, blank_lz, blink_mask, dp_in,
        input  busy, seg, dp, an
    );

    modport slave (
        input  value_in, value_load, text_mode, text_in, blank_lz, blink_mask, dp_in,
        output busy, seg, dp, an
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per cycle; result and overflow
// flag are committed together on the final busy cycle.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        value,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    // The working register must hold every decimal digit of the widest input,
    // even when fewer digits are displayed.
    localparam int WORK_DIGITS = (NUM_DIGITS > BIN_W/3 + 1) ? NUM_DIGITS : BIN_W/3 + 1;
    localparam int WORK_W      = 4 * WORK_DIGITS;
    localparam int CNT_W       = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = 64'(pow10(NUM_DIGITS));

    logic [BIN_W-1:0]        shift_reg;
    logic [WORK_W-1:0]       work_reg;
    logic [WORK_W-1:0]       adjusted;
    logic [WORK_W-1:0]       work_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    busy_reg;
    logic                    ovf_pend_reg;
    logic                    ovf_reg;
    logic [4*NUM_DIGITS-1:0] bcd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WORK_DIGITS; gi++) begin : g_adj
            assign adjusted[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                         work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
        end
    endgenerate

    assign work_next = WORK_W'({adjusted, shift_reg[BIN_W-1]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            ovf_pend_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            bcd_reg      <= '0;
        end else if (start && !busy_reg) begin
            shift_reg    <= value;
            work_reg     <= '0;
            cnt_reg      <= CNT_W'(BIN_W);
            busy_reg     <= 1'b1;
            ovf_pend_reg <= (64'(value) >= LIMIT);
        end else if (busy_reg) begin
            shift_reg <= shift_reg << 1;
            work_reg  <= work_next;
            cnt_reg   <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
                bcd_reg  <= work_next[4*NUM_DIGITS-1:0];
                ovf_reg  <= ovf_pend_reg;
            end
        end
    end

    assign busy     = busy_reg;
    assign bcd      = bcd_reg;
    assign overflow = ovf_reg;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver: scan/blink prescalers, digit
// source selection (number, dash, text), blanking and registered pin outputs.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 25000000
) (
    input logic                 clk,
    input logic                 rst,
    seg_scan_display_if.slave   bus
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

    logic [SCAN_W-1:0]       scan_cnt_reg;
    logic [IDX_W-1:0]        scan_idx_reg;
    logic [IDX_W-1:0]        scan_idx_next;
    logic [BLINK_W-1:0]      blink_cnt_reg;
    logic                    blink_phase_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    scan_tick;
    logic                    blink_tick;
    logic                    blink_off;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    overflow;
    logic                    conv_busy;
    logic [NUM_DIGITS-1:0][6:0] digit_seg;

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.value_load),
        .value    (bus.value_in),
        .busy     (conv_busy),
        .bcd      (bcd),
        .overflow (overflow)
    );

    // Digit 0 is never blanked; higher digits blank only when they and all above are zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_seg[gi] =
                bus.text_mode ? bus.text_in[7*gi +: 7] :
                overflow      ? SEG_DASH :
                ((gi > 0) && bus.blank_lz && (bcd[4*NUM_DIGITS-1:4*gi] == '0)) ? SEG_BLANK :
                seg_decode(bcd[4*gi +: 4]);
        end
    endgenerate

    assign scan_tick     = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    assign blink_tick    = (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1));
    assign scan_idx_next = (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
    assign blink_off     = blink_phase_reg & bus.blink_mask[scan_idx_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_reg    <= '0;
            scan_idx_reg    <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
            an_reg          <= '1;
        end else begin
            blink_cnt_reg <= blink_tick ? '0 : blink_cnt_reg + 1'b1;
            if (blink_tick) begin
                blink_phase_reg <= ~blink_phase_reg;
            end
            if (scan_tick) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= scan_idx_next;
                // Anode stays driven during blink-off so every slot keeps the same duty
                seg_reg      <= blink_off ? SEG_BLANK : digit_seg[scan_idx_reg];
                dp_reg       <= blink_off ? 1'b1 : ~bus.dp_in[scan_idx_reg];
                an_reg       <= ~(NUM_DIGITS'(1) << scan_idx_reg);
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.busy = conv_busy;
    assign bus.seg  = seg_reg;
    assign bus.dp   = dp_reg;
    assign bus.an   = an_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboarded bench: a cycle-level reference model predicts each scan slot from
// the displayed integer value; a monitor compares whenever the anodes change.
module tb_seg_scan_display;

    localparam int N     = 4;
    localparam int BW    = 14;
    localparam int SD    = 4;
    localparam int BD    = 64;
    localparam int LIMIT = 10000;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
    } disp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_display_if #(.NUM_DIGITS(N), .BIN_W(BW)) bus ();

    seg_scan_display #(
        .NUM_DIGITS (N),
        .BIN_W      (BW),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    disp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int events   = 0;

    // Reference model state, always reflecting the DUT state after the latest edge
    int m_scan, m_idx, m_blink, m_phase, m_val, m_pend, m_busy_left;
    logic [N-1:0] m_last_an;

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic disp_t predict(input int i);
        disp_t r;
        int p10;
        logic [7*N-1:0] tv;
        p10 = 1;
        for (int k = 0; k < i; k++) p10 = p10 * 10;
        tv = bus.text_in;
        if (bus.text_mode)                          r.seg = tv[7*i +: 7];
        else if (m_val >= LIMIT)                    r.seg = 7'b0111111;
        else if (bus.blank_lz && i > 0 && m_val < p10) r.seg = 7'h7F;
        else                                        r.seg = ref_glyph((m_val / p10) % 10);
        r.dp = ~bus.dp_in[i];
        if (m_phase == 1 && bus.blink_mask[i]) begin
            r.seg = 7'h7F;
            r.dp  = 1'b1;
        end
        r.an = ~(N'(1) << i);
        return r;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_idx = 0; m_blink = 0; m_phase = 0;
        m_val = 0; m_pend = 0; m_busy_left = 0; m_last_an = '1;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        disp_t e;
        if (rst) begin
            model_reset();
        end else begin
            checks++;
            if (bus.busy !== (m_busy_left > 0)) begin
                failures++;
                $display("FAIL busy t=%0t actual=%b required=%b", $time, bus.busy, m_busy_left > 0);
            end
            if (m_scan == SD - 1) begin
                e = predict(m_idx);
                exp_q.push_back(e);
                m_last_an = e.an;
                m_idx  = (m_idx + 1) % N;
                m_scan = 0;
            end else begin
                m_scan++;
            end
            if (m_blink == BD - 1) begin
                m_blink = 0;
                m_phase = 1 - m_phase;
            end else begin
                m_blink++;
            end
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_val = m_pend;
            end else if (bus.value_load) begin
                m_pend = int'(bus.value_in);
                m_busy_left = BW;
            end
        end
    end

    // Monitor: every anode change is one presented display slot
    logic [N-1:0] prev_an = '1;
    always @(negedge clk) begin
        disp_t e;
        if (bus.an !== prev_an) begin
            prev_an = bus.an;
            events++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL display t=%0t unexpected slot seg=%h dp=%b an=%b", $time, bus.seg, bus.dp, bus.an);
            end else begin
                e = exp_q.pop_front();
                if ({bus.seg, bus.dp, bus.an} !== e) begin
                    failures++;
                    $display("FAIL display t=%0t actual seg=%h dp=%b an=%b required seg=%h dp=%b an=%b",
                             $time, bus.seg, bus.dp, bus.an, e.seg, e.dp, e.an);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int v);
        bus.value_in   = BW'(v);
        bus.value_load = 1'b1;
        step(1);
        bus.value_load = 1'b0;
    endtask

    // Load an idle converter and measure the busy window length
    task automatic load_measured(input int v);
        int cnt;
        pulse_load(v);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 40) begin
            cnt++;
            step(1);
        end
        check($sformatf("busy_len_%0d", v), cnt, BW);
        $display("load %0d busy_cycles=%0d", v, cnt);
    endtask

    task automatic reset_mid();
        int guard;
        guard = 0;
        while (m_scan == 0 && guard < 10) begin
            step(1);
            guard++;
        end
        if (m_last_an != '1) exp_q.push_back('{seg: 7'h7F, dp: 1'b1, an: '1});
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp", bus.dp, 1);
        check("rst_an", bus.an, 4'hF);
        step(2);
        rst = 1'b0;
        $display("mid-conversion reset applied");
    endtask

    initial begin
        bus.value_in   = '0;
        bus.value_load = 1'b0;
        bus.text_mode  = 1'b0;
        bus.text_in    = '0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        bus.dp_in      = '0;
        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("pre_tick_seg", bus.seg, 7'h7F);
            check("pre_tick_an", bus.an, 4'hF);
            check("pre_tick_dp", bus.dp, 1);
        end
        step(20);

        load_measured(1234);   step(20);
        load_measured(12000);  step(20);
        load_measured(9999);   step(20);

        bus.blank_lz = 1'b1;
        load_measured(7);      step(20);
        load_measured(0);      step(20);

        bus.text_mode  = 1'b1;
        bus.text_in    = {7'h06, 7'h08, 7'h12, 7'h11};
        bus.blink_mask = 4'b0001;
        bus.dp_in      = 4'b0100;
        step(100);
        load_measured(5);
        step(200);

        bus.text_mode  = 1'b0;
        bus.blink_mask = '0;
        bus.blank_lz   = 1'b0;
        bus.dp_in      = '0;
        pulse_load(1234);
        step(4);
        reset_mid();
        step(20);
        pulse_load(42);
        step(3);
        pulse_load(77);
        step(30);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: pulse_load(int'($urandom_range(0, 16383)));
                1: pulse_load(int'($urandom_range(0, 120)));
                2: begin
                    bus.blank_lz   = 1'($urandom_range(0, 1));
                    bus.dp_in      = N'($urandom);
                    bus.blink_mask = N'($urandom);
                end
                default: begin
                    bus.text_mode = 1'($urandom_range(0, 1));
                    bus.text_in   = (7*N)'($urandom);
                end
            endcase
            step(int'($urandom_range(1, 30)));
        end

        step(20);
        while (m_scan == 0) step(1);
        check("queue_drained", exp_q.size(), 0);
        check("display_events_seen", (events > 200) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment driver for N common-anode digits. It converts a binary score or reaction time to BCD sequentially, or shows raw text patterns such as mode names. It adds leading-zero blanking, per-digit blink, decimal points and overflow indication. It sits between the game controller and the board display pins, and generates its own scan and blink timing from the system clock.

## Interface
- NUM_DIGITS, 4: number of digits/anodes (1..8)
- BIN_W, 14: width of binary value input
- SCAN_DIV, 100000: clk cycles per digit slot
- BLINK_DIV, 25000000: clk cycles per blink phase toggle
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- value_in  in  BIN_W  binary value to display
- value_load  in  1  one-cycle strobe: capture value_in and start conversion
- busy  out  1  conversion in progress
- text_mode  in  1  1: show text_in; 0: show converted number
- text_in  in  7*NUM_DIGITS  raw active-low patterns; bits [7i+6:7i] drive digit i
- blank_lz  in  1  enable leading-zero blanking (numeric mode only)
- blink_mask  in  NUM_DIGITS  digits blanked during blink-off phase
- dp_in  in  NUM_DIGITS  decimal point request per digit (active high)
- seg  out  7  segments g..a, active low
- dp  out  1  decimal point, active low
- an  out  NUM_DIGITS  anodes, active low; an[0] = rightmost digit (10^0)

## Operation
- Reset state: seg=7'h7F, dp=1, an=all ones (all dark), busy=0, BCD register=0, overflow flag=0, scan index=0, prescalers=0, blink phase=0.
- Conversion: value_load with busy=0 captures value_in and starts a shift-add-3 (double-dabble) sequence, 1 bit per cycle.
  - busy goes high the cycle after the load and stays high exactly BIN_W cycles.
  - The BCD register (4*NUM_DIGITS bits) and overflow flag update atomically on the last busy cycle; the display shows the old value until then.
  - value_load while busy=1 is ignored; no queueing.
- Overflow: if the captured value >= 10^NUM_DIGITS, every digit shows dash 7'b0111111 in numeric mode; dp still honoured.
- Digit i source, numeric mode: decode(BCD digit i).
  - With blank_lz=1, digit i>0 is blank (7'h7F) when it and all higher digits are 0.
  - Digit 0 is never blanked; value 0 shows "0".
- Digit i source, text mode: text_in[7i+:7] verbatim; conversion state is unaffected and may run concurrently.
- Blink: while blink phase=1, digits with blink_mask[i]=1 output seg=7'h7F and dp=1. The anode is still driven so that scan duty stays uniform.
- dp = ~dp_in[i] for the active digit, except during blink-off.

## Timing
- Scan prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps and the scan index advances (NUM_DIGITS-1 wraps to 0).
- seg, dp and an are registered and change together, one cycle after the scan tick; no glitch between an and seg.
- Exactly one an bit is low at any time after the first tick.
- Between reset release and the first tick, outputs keep their reset values.
- Blink prescaler counts 0..BLINK_DIV-1 and toggles the phase at the terminal count; full blink period is 2*BLINK_DIV cycles.
- Input changes on text_mode, text_in, blank_lz, blink_mask and dp_in take effect at the next scan tick.
- Reset asserted mid-conversion aborts it: busy=0 and BCD=0 immediately; asynchronous, with no clock needed.

## Structure
- Package seg_pkg:
  - SEG_BLANK and SEG_DASH constants
  - digit patterns 0-9
  - letter patterns E, A, S, Y, r, g, U, H, d for mode-name text
  - function seg_decode(4-bit) returning SEG_BLANK for values >9
- Sub-module bin2bcd_seq (parameters BIN_W, NUM_DIGITS): start, value, busy, bcd, overflow.
  - Iterative double-dabble with an internal bit counter.
  - Overflow computed against 10^NUM_DIGITS at capture.
- Top level holds the prescalers, scan index, blanking/blink muxing and output registers.

## Test plan
Benches use SCAN_DIV=4, BLINK_DIV=64, NUM_DIGITS=4, BIN_W=14.
- Reset, then release with no stimulus -> seg=7F, dp=1, an=1111, busy=0 until the first tick; then an cycles 1110,1101,1011,0111 every 4 cycles showing "0" on an[0] and "0" elsewhere (blank_lz=0).
- Load 1234 -> busy high exactly 14 cycles; afterwards an=1110 shows 4 (7'b0011001), an=0111 shows 1 (7'b1111001).
- Load 12000 -> all four digits show 7'b0111111; then load 9999 -> shows 9999, overflow cleared.
- blank_lz=1, load 7 -> an[3:1] slots show 7F, an[0] shows 7'b1111000; load 0 -> only digit 0 lit with "0".
- text_mode=1 with text_in = "EASY" patterns, blink_mask=4'b0001 -> text shown verbatim; digit 0 dark for 64 cycles every 128; a load of 5 in this state does not change the text.
- Load 1234, assert rst 5 cycles into busy -> busy drops asynchronously, outputs return to reset values; after release a display of 0 and a fresh load of 42 work; a second value_load pulse while busy has no effect.
